// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/func
// fields, ALU operation codes and datapath mux select codes.
package cpu_ctrl_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MEM  = 4'd3,
    S_WB   = 4'd4,
    S_TRAP = 4'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_XOR = 3'b010,
    ALU_NOR = 3'b011,
    ALU_ADD = 3'b100,
    ALU_SUB = 3'b101,
    ALU_SLT = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  localparam logic [1:0] WRS_RT  = 2'b00;
  localparam logic [1:0] WRS_RD  = 2'b01;
  localparam logic [1:0] WRS_R31 = 2'b10;

  localparam logic [1:0] WDS_ALU = 2'b00;
  localparam logic [1:0] WDS_MEM = 2'b01;
  localparam logic [1:0] WDS_PC  = 2'b10;
  localparam logic [1:0] WDS_LUI = 2'b11;

  // lui bypasses the ALU through the imm<<16 write path; OR keeps it harmless.
  function automatic alu_op_e alu_op_for(input logic [5:0] op, input logic [5:0] fn);
    alu_op_e r;
    r = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SUB:   r = ALU_SUB;
          F_AND:   r = ALU_AND;
          F_OR:    r = ALU_OR;
          F_XOR:   r = ALU_XOR;
          F_NOR:   r = ALU_NOR;
          F_SLT:   r = ALU_SLT;
          F_SLL:   r = ALU_SLL;
          default: r = ALU_ADD;
        endcase
      end
      OP_ANDI:        r = ALU_AND;
      OP_ORI, OP_LUI: r = ALU_OR;
      OP_XORI:        r = ALU_XOR;
      OP_BEQ, OP_BNE: r = ALU_SUB;
      default:        r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps OP/func from the IR onto the
// class flags the sequencing FSM branches on.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_r,
  output logic       is_alu_imm,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_br,
  output logic       is_j,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_lui,
  output logic       ovf_chk,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    is_r       = 1'b0;
    is_alu_imm = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_br      = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    is_lui     = 1'b0;
    ovf_chk    = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADD, F_SUB: begin
            is_r    = 1'b1;
            ovf_chk = 1'b1;
          end
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLL: is_r = 1'b1;
          F_JR:    is_jr   = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        is_alu_imm = 1'b1;
        ovf_chk    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: is_alu_imm = 1'b1;
      OP_LUI:         is_lui  = 1'b1;
      OP_LW:          is_lw   = 1'b1;
      OP_SW:          is_sw   = 1'b1;
      OP_BEQ, OP_BNE: is_br   = 1'b1;
      OP_J:           is_j    = 1'b1;
      OP_JAL:         is_jal  = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the single-cycle datapath, with a
// retired-instruction counter. Define MULTICYCLE_TRAP_EN to trap on illegal opcodes.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OP,
  input  logic [5:0]         func,
  input  logic               ZF,
  input  logic               OF,
  output logic               PC_Write,
  output logic               IR_Write,
  output logic [1:0]         PC_s,
  output logic [1:0]         w_r_s,
  output logic [1:0]         wr_data_s,
  output logic               imm_s,
  output logic               rt_imm_s,
  output logic [2:0]         ALU_OP,
  output logic               Write_Reg,
  output logic               Mem_Write,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired,
  output logic               trap
);

  logic is_r, is_alu_imm, is_lw, is_sw, is_br, is_j, is_jal, is_jr, is_lui;
  logic ovf_chk, illegal;

  ctrl_decode u_decode (
    .op         (OP),
    .func       (func),
    .is_r       (is_r),
    .is_alu_imm (is_alu_imm),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_br      (is_br),
    .is_j       (is_j),
    .is_jal     (is_jal),
    .is_jr      (is_jr),
    .is_lui     (is_lui),
    .ovf_chk    (ovf_chk),
    .illegal    (illegal)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               of_q, of_d;
  logic               retire;

  always_comb begin
    state_d = S_IF;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (illegal) begin
`ifdef MULTICYCLE_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
`endif
        end else if (is_j || is_jal || is_jr) begin
          retire = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_br)               retire  = 1'b1;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (is_sw) retire  = 1'b1;
        else       state_d = S_WB;
      end
      S_WB: retire = 1'b1;
`ifdef MULTICYCLE_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IF;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    of_d      = (state_q == S_EX) ? OF : of_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      retired_q <= '0;
      of_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
      state_q   <= state_d;
      retired_q <= retired_d;
      of_q      <= of_d;
    end
  end

  // Strobes and selects are a function of the current state and IR fields;
  // reset forces them all inactive so an abandoned instruction writes nothing.
  always_comb begin
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    PC_s      = PCS_PC4;
    w_r_s     = WRS_RT;
    wr_data_s = WDS_ALU;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    ALU_OP    = ALU_AND;
    Write_Reg = 1'b0;
    Mem_Write = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          IR_Write = 1'b1;
          PC_Write = 1'b1;
          PC_s     = PCS_PC4;
        end
        S_ID: begin
          if (is_j || is_jal) begin
            PC_Write = 1'b1;
            PC_s     = PCS_JMP;
          end
          if (is_jal) begin
            Write_Reg = 1'b1;
            w_r_s     = WRS_R31;
            wr_data_s = WDS_PC;
          end
          if (is_jr) begin
            PC_Write = 1'b1;
            PC_s     = PCS_RS;
          end
        end
        S_EX, S_MEM, S_WB: begin
          // ALU selects stay put through MEM/WB so Mem_Addr and ALU_F remain stable.
          ALU_OP   = alu_op_for(OP, func);
          rt_imm_s = is_alu_imm || is_lui || is_lw || is_sw;
          imm_s    = !(is_alu_imm && (OP != OP_ADDI));
          if (state_q == S_EX && is_br) begin
            PC_s     = PCS_BR;
            PC_Write = (OP == OP_BNE) ? !ZF : ZF;
          end
          if (state_q == S_MEM) Mem_Write = is_sw;
          if (state_q == S_WB) begin
            Write_Reg = !(ovf_chk && of_q);
            w_r_s     = is_r ? WRS_RD : WRS_RT;
            if (is_lw)       wr_data_s = WDS_MEM;
            else if (is_lui) wr_data_s = WDS_LUI;
            else             wr_data_s = WDS_ALU;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_TRAP_EN
  assign trap = !rst && (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

  assign state   = STATE_W'(state_q);
  assign retired = retired_q;

endmodule
